// File: rtl/fetch_unit.sv
// Program-sequencing front end: PC register, IDLE/RUN/HALT control and
// saturating cycle / taken-branch counters for a single-cycle core.
module fetch_unit #(
    parameter int PW         = 10,
    parameter int CW         = 16,
    parameter int START_ADDR = 0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Branch,
    input  logic          Taken,
    input  logic [PW-1:0] Target,
    input  logic          Ack,
    output logic [PW-1:0] ProgCtr,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCnt,
    output logic [CW-1:0] BrCnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [PW-1:0] START_PC = PW'(START_ADDR);

    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] br_q, br_d;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        br_d    = br_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (state_q == IDLE) pc_d = START_PC;
                if (Start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cyc_d   = '0;
                    br_d    = '0;
                end
            end
            RUN: begin
                cyc_d = sat_inc(cyc_q);
                // Halt outranks a simultaneous taken branch; PC stays on the halt.
                if (Ack) begin
                    state_d = HALT;
                end else if (Branch && Taken) begin
                    pc_d = Target;
                    br_d = sat_inc(br_q);
                end else begin
                    pc_d = pc_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            cyc_q   <= '0;
            br_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            br_q    <= br_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign Running  = (state_q == RUN);
    assign Done     = (state_q == HALT);
    assign CycleCnt = cyc_q;
    assign BrCnt    = br_q;

endmodule
